// File: rtl/regfile_write_arbiter_pkg.sv
// regfile_write_arbiter_pkg: shared request entry and write-source types for the write-port arbiter.
package regfile_write_arbiter_pkg;
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } regwrite_req_type;
  typedef enum logic [1:0] {WR_NONE, WR_WB, WR_AUX} write_src_type;
endpackage

// File: rtl/regwrite_fifo.sv
// regwrite_fifo: strict-order buffer of aux write requests with a per-entry valid/rd view for hazard masks.
module regwrite_fifo
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  regwrite_req_type           din,
  input  logic                       pop,
  output regwrite_req_type           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic [DEPTH-1:0]           valid,
  output logic [DEPTH-1:0][4:0]      rds
);
  localparam int AW = $clog2(DEPTH);
  regwrite_req_type mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic full, do_push, do_pop;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  for (genvar i = 0; i < DEPTH; i++) begin : g_view
    assign valid[i] = {1'b0, AW'(i) - rd_ptr} < count;
    assign rds[i]   = mem[i].rd;
  end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= (do_push && !do_pop) ? count + 1'b1 : (!do_push && do_pop) ? count - 1'b1 : count;
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register-file write port between write-back (primary) and a buffered
// aux requester, forcing a one-cycle pipeline stall when the aux head starves for MAX_WAIT cycles.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_RegWrite,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        aux_valid,
  output logic        aux_ready,
  input  logic [4:0]  aux_rd,
  input  logic [31:0] aux_data,
  output logic        RegWrite,
  output logic [4:0]  write_id,
  output logic [31:0] write_data,
  output logic        pipe_stall,
  output logic [31:0] aux_pending
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int WW = $clog2(MAX_WAIT) + 1;
  regwrite_req_type head;
  logic [CW-1:0] count;
  logic empty, wb_req, push, pop;
  logic [FIFO_DEPTH-1:0] ent_valid;
  logic [FIFO_DEPTH-1:0][4:0] ent_rd;
  logic [WW-1:0] wait_cnt;
  write_src_type src;
  assign wb_req = wb_RegWrite && wb_rd != 5'd0;
  // A stall cycle exists only to drain the head; the WB request is re-presented next cycle.
  assign src = !rst ? WR_NONE
             : (pipe_stall && !empty) ? WR_AUX
             : wb_req ? WR_WB
             : !empty ? WR_AUX : WR_NONE;
  assign pop        = src == WR_AUX;
  assign aux_ready  = rst && count < CW'(FIFO_DEPTH);
  assign push       = aux_valid && aux_ready && aux_rd != 5'd0;
  assign RegWrite   = src != WR_NONE;
  assign write_id   = src == WR_WB ? wb_rd : src == WR_AUX ? head.rd : 5'd0;
  assign write_data = src == WR_WB ? wb_data : src == WR_AUX ? head.data : 32'd0;
  regwrite_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .din('{rd: aux_rd, data: aux_data}), .pop(pop),
    .head(head), .count(count), .empty(empty), .valid(ent_valid), .rds(ent_rd)
  );
  always_comb begin
    aux_pending = '0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (ent_valid[i]) aux_pending[ent_rd[i]] = 1'b1;
    aux_pending[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wait_cnt   <= '0;
      pipe_stall <= 1'b0;
    end else begin
      wait_cnt   <= (empty || pop) ? '0 : (wait_cnt == WW'(MAX_WAIT)) ? wait_cnt : wait_cnt + 1'b1;
      pipe_stall <= !empty && !pop && wait_cnt == WW'(MAX_WAIT - 1);
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_regfile_write_arbiter;
  localparam int DEPTH = 2;
  localparam int MAX_WAIT = 4;
  typedef struct {logic [4:0] rd; logic [31:0] d;} ent_t;
  logic clk = 0, rst = 0;
  logic wb_RegWrite = 0, aux_valid = 0;
  logic [4:0] wb_rd = 0, aux_rd = 0;
  logic [31:0] wb_data = 0, aux_data = 0;
  logic aux_ready, RegWrite, pipe_stall;
  logic [4:0] write_id;
  logic [31:0] write_data, aux_pending;
  int total = 0, bad = 0;
  ent_t q[$];
  int losses = 0;
  bit stall = 0, was_stall = 0;
  logic s_stall, s_we, s_ready;
  logic [4:0] s_id;
  logic [31:0] s_data, s_pend;

  regfile_write_arbiter #(.FIFO_DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_rd(aux_rd), .aux_data(aux_data),
    .RegWrite(RegWrite), .write_id(write_id), .write_data(write_data),
    .pipe_stall(pipe_stall), .aux_pending(aux_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs are already driven (just after a falling edge); check, clock once, advance the model.
  task automatic step();
    bit wbv, ga, ew, er, nonempty;
    logic [4:0] eid;
    logic [31:0] ed, ep;
    #1;
    s_stall = pipe_stall; s_we = RegWrite; s_id = write_id; s_data = write_data;
    s_ready = aux_ready; s_pend = aux_pending;
    if (!rst) begin
      q.delete(); losses = 0; stall = 0; was_stall = 0;
      chk("rst_we", RegWrite, 0);
      chk("rst_ready", aux_ready, 0);
      chk("rst_pend", aux_pending, 0);
      chk("rst_stall", pipe_stall, 0);
      @(posedge clk);
    end else begin
      wbv = wb_RegWrite && wb_rd != 0;
      ga = q.size() > 0 && (stall || !wbv);
      ew = ga || (wbv && !stall);
      eid = ga ? q[0].rd : ew ? wb_rd : 5'd0;
      ed = ga ? q[0].d : ew ? wb_data : 32'd0;
      er = q.size() < DEPTH;
      ep = 0;
      foreach (q[i]) ep[q[i].rd] = 1'b1;
      chk("we", RegWrite, ew);
      chk("id", write_id, eid);
      chk("data", write_data, ed);
      chk("ready", aux_ready, er);
      chk("pend", aux_pending, ep);
      chk("stall", pipe_stall, stall);
      was_stall = stall;
      @(posedge clk);
      nonempty = q.size() > 0;
      if (ga) void'(q.pop_front());
      if (aux_valid && er && aux_rd != 0) q.push_back('{aux_rd, aux_data});
      losses = (ga || !nonempty) ? 0 : losses + 1;
      stall = !ga && nonempty && losses == MAX_WAIT;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                       input logic av, input logic [4:0] ard, input logic [31:0] ad);
    wb_RegWrite = we; wb_rd = wrd; wb_data = wd;
    aux_valid = av; aux_rd = ard; aux_data = ad;
  endtask

  initial begin
    @(negedge clk);
    // reset with both sources requesting
    drive(1, 4, 32'h1111, 1, 5, 32'h2222);
    step(); step();
    rst = 1;
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("release_ready", s_ready, 1);
    // idle aux write
    drive(0, 0, 0, 1, 5, 32'hDEAD_BEEF);
    step();
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("idle_pend5", s_pend[5], 1);
    chk("idle_we", s_we, 1);
    chk("idle_id", s_id, 5);
    chk("idle_data", s_data, 32'hDEAD_BEEF);
    step();
    chk("idle_pend_clr", s_pend, 0);
    // priority and starvation stall
    for (int c = 0; c < 8; c++) begin
      drive(1, 3, 32'h300 + c, c == 0, 7, 32'h7777);
      step();
      chk("prio_stall", s_stall, c == 5);
      chk("prio_id", s_id, c == 5 ? 5'd7 : 5'd3);
    end
    // full FIFO behind busy WB
    for (int c = 0; c < 8; c++) begin
      drive(1, 3, 32'h400 + c, c < 2, 5'(10 + c), 32'hA0 + c);
      step();
      if (c == 2) chk("full_ready", s_ready, 0);
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) step();
    // x0 handling
    drive(1, 0, 32'hBAD, 1, 9, 32'h9999);
    step();
    drive(1, 0, 32'hBAD, 1, 0, 32'h0BAD);
    step();
    chk("x0_id", s_id, 9);
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("x0_we", s_we, 0);
    chk("x0_pend", s_pend, 0);
    // mid-run reset drops queued entries
    drive(1, 3, 32'h55, 1, 12, 32'hC);
    step();
    drive(1, 3, 32'h56, 1, 13, 32'hD);
    step();
    rst = 0;
    step();
    rst = 1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) begin
      step();
      chk("midrst_we", s_we, 0);
    end
    // randomized traffic; WB is held and re-presented after a stall cycle
    for (int n = 0; n < 3000; n++) begin
      if (!was_stall)
        {wb_RegWrite, wb_rd, wb_data} = {1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), 32'($urandom)};
      aux_valid = 1'($urandom_range(0, 2) == 0);
      aux_rd = 5'($urandom_range(0, 31));
      aux_data = 32'($urandom);
      rst = !($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
